// File: rtl/fib_seq_ctrl_pkg.sv
// Shared definitions for the Fibonacci sequencer and its companion ALU:
// ALU opcode constants and the controller state encoding.
package fib_seq_ctrl_pkg;

    localparam logic [4:0] A_NOP = 5'h00;
    localparam logic [4:0] A_ADD = 5'h01;
    localparam logic [4:0] A_SUB = 5'h02;
    localparam logic [4:0] A_AND = 5'h03;
    localparam logic [4:0] A_OR  = 5'h04;
    localparam logic [4:0] A_XOR = 5'h05;
    localparam logic [4:0] A_NOR = 5'h06;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } fib_state_t;

endpackage

// File: rtl/fib_seq_ctrl_alu.sv
// Small registered ALU used next to the Fibonacci sequencer. It has no reset,
// and any opcode it does not recognise (including NOP) leaves the result unchanged.
module fib_seq_ctrl_alu
    import fib_seq_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [4:0]        i_op,
    output logic [DATA_W-1:0] o_result
);

    logic [DATA_W-1:0] r_result;

    // Compute on the issued opcode; NOP keeps the previous result for the consumer.
    always_ff @(posedge i_clk) begin
        case (i_op)
            A_ADD:   r_result <= i_a + i_b;
            A_SUB:   r_result <= i_a - i_b;
            A_AND:   r_result <= i_a & i_b;
            A_OR:    r_result <= i_a | i_b;
            A_XOR:   r_result <= i_a ^ i_b;
            A_NOR:   r_result <= ~(i_a | i_b);
            default: r_result <= r_result;
        endcase
    end

    assign o_result = r_result;

endmodule

// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequence controller. It drives an external registered ALU with
// ADD and NOP opcodes, and produces one new term every two cycles until
// n_terms terms have been produced.
module fib_seq_ctrl
    import fib_seq_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed_a,
    input  logic [DATA_W-1:0] seed_b,
    input  logic [CNT_W-1:0]  n_terms,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] term,
    output logic              term_valid,
    output logic              busy,
    output logic              done
);

    fib_state_t        r_state;
    logic [DATA_W-1:0] r_f0;
    logic [DATA_W-1:0] r_f1;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_n;
    logic [DATA_W-1:0] r_term;
    logic              r_termValid;
    logic              r_busy;
    logic              r_done;
    logic [4:0]        r_aluOp;
    logic [CNT_W-1:0]  w_cntNext;

    assign w_cntNext = r_cnt + CNT_W'(1);

    // Sequencer FSM: the ADD opcode is registered when ISSUE is entered, so the ALU
    // result is ready at the end of WAIT, the only state that reads alu_out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_f0        <= '0;
            r_f1        <= '0;
            r_cnt       <= '0;
            r_n         <= '0;
            r_term      <= '0;
            r_termValid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aluOp     <= A_NOP;
        end else begin
            r_termValid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_aluOp <= A_NOP;
                    if (start) begin
                        r_f0  <= seed_a;
                        r_f1  <= seed_b;
                        r_cnt <= '0;
                        r_n   <= n_terms;
                        if (n_terms == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_aluOp <= A_ADD;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_aluOp <= A_NOP;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_term      <= alu_out;
                    r_termValid <= 1'b1;
                    r_f0        <= r_f1;
                    r_f1        <= alu_out;
                    r_cnt       <= w_cntNext;
                    if (w_cntNext == r_n) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_aluOp <= A_NOP;
                        r_state <= S_IDLE;
                    end else begin
                        r_aluOp <= A_ADD;
                        r_state <= S_ISSUE;
                    end
                end
                default: begin
                    r_aluOp <= A_NOP;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_a      = r_f0;
    assign alu_b      = r_f1;
    assign alu_op     = r_aluOp;
    assign term       = r_term;
    assign term_valid = r_termValid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: doc/fib_seq_ctrl.md
FIB_SEQ_CTRL -- requirements
Module: fib_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width matching the ALU datapath.
REQ-002 SHALL have parameter CNT_W, default 6, width of the term-count input.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  request a run; sampled only in IDLE.
REQ-006 SHALL have port seed_a  input  DATA_W  first seed F0; captured at start.
REQ-007 SHALL have port seed_b  input  DATA_W  second seed F1; captured at start.
REQ-008 SHALL have port n_terms  input  CNT_W  number of terms to generate; captured at start.
REQ-009 SHALL have port alu_a  output  DATA_W  ALU operand A, driven directly from register f0.
REQ-010 SHALL have port alu_b  output  DATA_W  ALU operand B, driven directly from register f1.
REQ-011 SHALL have port alu_op  output  5  ALU opcode; only 5'h00 (NOP) and 5'h01 (ADD) are used.
REQ-012 SHALL have port alu_out  input  DATA_W  registered ALU result, valid one clock after ADD is issued.
REQ-013 SHALL have port term  output  DATA_W  latest generated term.
REQ-014 SHALL have port term_valid  output  1  one-cycle pulse per new term.
REQ-015 SHALL have port busy  output  1  high from the start-accept edge until the done edge.
REQ-016 SHALL have port done  output  1  one-cycle pulse at the end of a run.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-018 IDLE with start=1 SHALL, at the next edge, load f0<=seed_a, f1<=seed_b, cnt<=0, n<=n_terms, busy<=1, and go to ISSUE; if n_terms==0, SHALL stay in IDLE and pulse done with busy=0.
REQ-019 ISSUE SHALL drive alu_op=ADD for exactly one cycle, then go to WAIT.
REQ-020 In every state other than ISSUE, alu_op SHALL be NOP so the ALU holds its result.
REQ-021 WAIT SHALL, at its ending edge: term<=alu_out, term_valid<=1, f0<=f1, f1<=alu_out, cnt<=cnt+1.
REQ-022 After REQ-021, if cnt+1==n the FSM SHALL go to IDLE with done<=1 and busy<=0 on the same edge as the last term_valid; otherwise it SHALL go to ISSUE.
REQ-023 Throughput SHALL be one term per 2 cycles; term i (0-based) SHALL be valid in the cycle after edge E0+2+2i, where E0 is the start-accept edge.
REQ-024 Addition SHALL wrap modulo 2^DATA_W with overflow ignored; term values SHALL be unsigned bit patterns.
REQ-025 start while busy SHALL be ignored; seed_a, seed_b and n_terms changes during a run SHALL have no effect.
REQ-026 term SHALL hold its last value between pulses and after done.

Reset
REQ-027 rst_n=0 at an edge SHALL force state=IDLE, f0=f1=0, cnt=0, term=0, term_valid=0, busy=0, done=0, alu_op=NOP, including mid-run; no done SHALL follow an aborted run.
REQ-028 The controller SHALL NOT depend on the ALU's output value after reset (the ALU has no reset); alu_out SHALL be read only in WAIT.

Structure
REQ-029 ALU opcode constants (A_NOP=5'h00 … A_NOR=5'h06) and the FSM state encoding SHALL live in a shared package used by both the ALU and this block.
REQ-030 No sub-module SHALL be instantiated inside this block; the ALU SHALL be instantiated alongside it at the top level and in the bench.

Verification
REQ-031 seeds 1,1, n_terms=5 -> term_valid pulses carrying 2,3,5,8,13 at E0+3,+5,+7,+9,+11; done with the 13 pulse; busy low afterwards.
REQ-032 seeds 0,0, n_terms=3 -> three pulses of 0; alu_op shows ADD in exactly 3 cycles.
REQ-033 seeds 32'hFFFFFFFF,2, n_terms=2 -> terms 1, 3 (wrap-around).
REQ-034 n_terms=0 with start -> done pulse, busy=0 throughout, no term_valid, alu_op stays NOP.
REQ-035 rst_n=0 after the 2nd term of a 10-term run -> all outputs return to reset values next cycle; no done; a new start then runs correctly.
REQ-036 start held high for a whole run with seeds changed mid-run -> output sequence unchanged; a new run begins the cycle after done only if start is still high.
